// File: rtl/rv32v_element_sequencer_pkg.sv
// Shared types and constants for the vector element sequencer.
//  - sew_t        : element-width encoding (SEW8/16/32 legal, SEW64 and above rejected)
//  - vseq_state_t : sequencer FSM states
//  - ELEM_IDX_W   : element-index width (VLEN_WIDTH+1, holds vl up to 128)
//  - VLENB_LOG2   : log2 of bytes per vector register for the default VLEN
package rv32v_element_sequencer_pkg;

  localparam int unsigned VLEN_WIDTH = 7;
  localparam int unsigned ELEM_IDX_W = VLEN_WIDTH + 1;
  localparam int unsigned VLENB_LOG2 = 4;

  typedef enum logic [2:0] {
    Sew8  = 3'd0,
    Sew16 = 3'd1,
    Sew32 = 3'd2,
    Sew64 = 3'd3
  } sew_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone,
    StErr
  } vseq_state_t;

endpackage

// File: rtl/rv32v_elem_addr_calc.sv
// Per-lane address calculation for one element index.
//  idx      : element index
//  sew      : latched element width (0=8b, 1=16b, 2=32b)
//  vl       : latched vector length
//  active   : idx < vl
//  vreg_off : register within the LMUL group holding this element
//  byte_off : byte offset of the element inside that register
module rv32v_elem_addr_calc #(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned VLENB = 16
) (
  input  logic [IDX_W-1:0]         idx,
  input  logic [1:0]               sew,
  input  logic [IDX_W-1:0]         vl,
  output logic                     active,
  output logic [2:0]               vreg_off,
  output logic [$clog2(VLENB)-1:0] byte_off
);

  localparam int unsigned BoW = $clog2(VLENB);

  // Elements per register is VLENB >> sew, so the register number is idx >> (log2(VLENB)-sew).
  logic [2:0] shamt;
  assign shamt = 3'(BoW) - {1'b0, sew};

  assign active   = idx < vl;
  assign vreg_off = 3'(idx >> shamt);
  assign byte_off = BoW'(idx << sew);

endmodule

// File: rtl/rv32v_element_sequencer.sv
// Steps one decoded vector instruction through elements vstart..vl-1, issuing NUM_LANES
// consecutive element indices per beat with per-lane register/byte offsets.
//  CLK, RST     : clock, synchronous active-high reset
//  start/ready  : instruction handshake from issue (sew/vl/vstart sampled on acceptance)
//  stall        : lanes cannot take the current beat; beat outputs hold
//  kill         : abort the current instruction, back to idle without done/illegal
//  beat_valid   : elem_idx/lane_active/vreg_off/byte_off/last_beat are valid
//  done         : one-cycle pulse after the final beat (or immediately for an empty range)
//  illegal      : one-cycle pulse when sew exceeds SEW32
module rv32v_element_sequencer
  import rv32v_element_sequencer_pkg::*;
#(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned VLENB     = 16,
  parameter int unsigned IDX_W     = ELEM_IDX_W
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 start,
  output logic                                 ready,
  input  logic [2:0]                           sew,
  input  logic [IDX_W-1:0]                     vl,
  input  logic [IDX_W-1:0]                     vstart,
  input  logic                                 stall,
  input  logic                                 kill,
  output logic                                 beat_valid,
  output logic [NUM_LANES*IDX_W-1:0]           elem_idx,
  output logic [NUM_LANES-1:0]                 lane_active,
  output logic [NUM_LANES*3-1:0]               vreg_off,
  output logic [NUM_LANES*$clog2(VLENB)-1:0]   byte_off,
  output logic                                 last_beat,
  output logic                                 done,
  output logic                                 illegal
);

  localparam int unsigned BoW = $clog2(VLENB);

  vseq_state_t      state_q;
  logic [IDX_W-1:0] base_q;
  logic [IDX_W-1:0] vl_q;
  logic [1:0]       sew_q;

  // One extra bit so base+NUM_LANES cannot wrap near vl=128.
  logic [IDX_W:0] beat_end;
  assign beat_end  = {1'b0, base_q} + (IDX_W+1)'(NUM_LANES);
  assign last_beat = beat_end >= {1'b0, vl_q};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      base_q  <= '0;
      vl_q    <= '0;
      sew_q   <= '0;
    end else if (kill) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sew_q  <= sew[1:0];
            vl_q   <= vl;
            base_q <= vstart;
            if (sew > Sew32) begin
              state_q <= StErr;
            end else if (vstart >= vl) begin
              state_q <= StDone;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (!stall) begin
            base_q <= base_q + IDX_W'(NUM_LANES);
            if (last_beat) begin
              state_q <= StDone;
            end
          end
        end
        StDone:  state_q <= StIdle;
        StErr:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready      = (state_q == StIdle) && !RST;
  assign beat_valid = (state_q == StRun);
  assign done       = (state_q == StDone);
  assign illegal    = (state_q == StErr);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [IDX_W-1:0] idx;
    assign idx = base_q + IDX_W'(i);
    assign elem_idx[i*IDX_W +: IDX_W] = idx;

    rv32v_elem_addr_calc #(
      .IDX_W (IDX_W),
      .VLENB (VLENB)
    ) u_addr_calc (
      .idx      (idx),
      .sew      (sew_q),
      .vl       (vl_q),
      .active   (lane_active[i]),
      .vreg_off (vreg_off[i*3 +: 3]),
      .byte_off (byte_off[i*BoW +: BoW])
    );
  end

endmodule

// File: tb/tb_rv32v_element_sequencer.sv
module tb_rv32v_element_sequencer;

  localparam int NL = 2;
  localparam int VB = 16;
  localparam int IW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ready;
  logic [2:0]  sew;
  logic [7:0]  vl;
  logic [7:0]  vstart;
  logic        stall;
  logic        kill;
  logic        beat_valid;
  logic [15:0] elem_idx;
  logic [1:0]  lane_active;
  logic [5:0]  vreg_off;
  logic [7:0]  byte_off;
  logic        last_beat;
  logic        done;
  logic        illegal;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  rv32v_element_sequencer #(
    .NUM_LANES (NL),
    .VLENB     (VB),
    .IDX_W     (IW)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .start       (start),
    .ready       (ready),
    .sew         (sew),
    .vl          (vl),
    .vstart      (vstart),
    .stall       (stall),
    .kill        (kill),
    .beat_valid  (beat_valid),
    .elem_idx    (elem_idx),
    .lane_active (lane_active),
    .vreg_off    (vreg_off),
    .byte_off    (byte_off),
    .last_beat   (last_beat),
    .done        (done),
    .illegal     (illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: element idx lives in register idx/(elements per reg) at byte (idx*bytes)%VLENB.
  task automatic check_beat(input int base, input logic [2:0] s, input int v);
    logic [15:0] e_idx;
    logic [1:0]  e_act;
    logic [5:0]  e_vreg;
    logic [7:0]  e_byte;
    int          idx;
    int          bytes_per_elem;
    bytes_per_elem = 1 << s;
    for (int i = 0; i < NL; i++) begin
      idx                = base + i;
      e_idx[i*8 +: 8]    = idx[7:0];
      e_act[i]           = (idx < v);
      e_vreg[i*3 +: 3]   = 3'((idx / (VB / bytes_per_elem)) % 8);
      e_byte[i*4 +: 4]   = 4'((idx * bytes_per_elem) % VB);
    end
    check("beat_valid", 32'(beat_valid), 1);
    check("elem_idx", 32'(elem_idx), 32'(e_idx));
    check("lane_active", 32'(lane_active), 32'(e_act));
    check("vreg_off", 32'(vreg_off), 32'(e_vreg));
    check("byte_off", 32'(byte_off), 32'(e_byte));
    check("last_beat", 32'(last_beat), 32'(base + NL >= v));
    check("no_done_in_run", 32'(done), 0);
  endtask

  // Issue one instruction and follow it to completion, error or kill.
  task automatic run_instr(input logic [2:0] s, input int v, input int vs, input int stall_base,
                           input int stall_n, input int pct, input int kill_base);
    int base;
    int stalls_left;
    @(negedge clk);
    check("ready_before_start", 32'(ready), 1);
    start  = 1'b1;
    sew    = s;
    vl     = v[7:0];
    vstart = vs[7:0];
    stall  = 1'b0;
    kill   = 1'b0;
    @(negedge clk);
    start  = 1'b0;
    // Mid-run input changes must be ignored.
    sew    = 3'($urandom);
    vl     = 8'($urandom);
    vstart = 8'($urandom);
    if (s > 3'd2) begin
      check("illegal_pulse", 32'(illegal), 1);
      check("err_no_beat", 32'(beat_valid), 0);
      check("err_no_done", 32'(done), 0);
      @(negedge clk);
      check("illegal_once", 32'(illegal), 0);
      check("err_no_beat2", 32'(beat_valid), 0);
      check("err_ready", 32'(ready), 1);
      return;
    end
    base        = vs;
    stalls_left = stall_n;
    while (base < v) begin
      check_beat(base, s, v);
      if (base == kill_base) begin
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_no_beat", 32'(beat_valid), 0);
        check("kill_no_done", 32'(done), 0);
        check("kill_ready", 32'(ready), 1);
        return;
      end
      if (base == stall_base && stalls_left > 0) begin
        stall = 1'b1;
        stalls_left--;
      end else begin
        stall = ($urandom_range(0, 99) < pct);
      end
      if (!stall) base += NL;
      @(negedge clk);
    end
    stall = 1'b0;
    check("done_pulse", 32'(done), 1);
    check("done_no_beat", 32'(beat_valid), 0);
    @(negedge clk);
    check("done_once", 32'(done), 0);
    check("done_ready", 32'(ready), 1);
  endtask

  initial begin
    int          v;
    int          vs;
    int          kb;
    int          nbeats;
    logic [2:0]  s;

    rst    = 1'b1;
    start  = 1'b0;
    sew    = 3'd0;
    vl     = 8'd0;
    vstart = 8'd0;
    stall  = 1'b0;
    kill   = 1'b0;

    // Reset state, with start asserted to show it is ignored under reset.
    @(negedge clk);
    start = 1'b1;
    vl    = 8'd4;
    @(negedge clk);
    check("rst_ready", 32'(ready), 0);
    check("rst_beat_valid", 32'(beat_valid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_illegal", 32'(illegal), 0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(ready), 1);
    check("post_rst_beat", 32'(beat_valid), 0);

    // Directed scenarios.
    run_instr(3'd0, 5, 0, -1, 0, 0, -1);   // SEW8, 3 beats, last lane1 inactive
    run_instr(3'd2, 32, 0, -1, 0, 0, -1);  // SEW32, 16 beats
    run_instr(3'd1, 8, 0, 2, 3, 0, -1);    // stall 3 cycles on base 2
    run_instr(3'd0, 0, 0, -1, 0, 0, -1);   // vl=0
    run_instr(3'd0, 6, 6, -1, 0, 0, -1);   // vstart=vl
    run_instr(3'd3, 10, 0, -1, 0, 0, -1);  // SEW64 illegal
    run_instr(3'd0, 16, 0, -1, 0, 0, 2);   // kill on second beat
    run_instr(3'd0, 6, 3, -1, 0, 0, -1);   // beats 3,4 / 5,6

    // kill together with start in idle: start ignored.
    @(negedge clk);
    start  = 1'b1;
    kill   = 1'b1;
    sew    = 3'd0;
    vl     = 8'd5;
    vstart = 8'd0;
    @(negedge clk);
    start = 1'b0;
    kill  = 1'b0;
    check("kill_start_no_beat", 32'(beat_valid), 0);
    check("kill_start_no_done", 32'(done), 0);
    check("kill_start_ready", 32'(ready), 1);

    // Stall while idle has no effect on a following instruction.
    stall = 1'b1;
    @(negedge clk);
    check("idle_stall_ready", 32'(ready), 1);
    stall = 1'b0;

    // Randomized instructions.
    for (int n = 0; n < 40; n++) begin
      s  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      v  = $urandom_range(0, 128);
      vs = $urandom_range(0, v + 2);
      kb = -1;
      if (s <= 3'd2 && vs < v && $urandom_range(0, 4) == 0) begin
        nbeats = (v - vs + NL - 1) / NL;
        kb     = vs + NL * $urandom_range(0, nbeats - 1);
      end
      run_instr(s, v, vs, -1, 0, 30, kb);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
